// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
//   Sink end of a VGA pixel interface. Registers HS/VS/BLANK_n/RGB once,
//   recovers active-pixel coordinates and checks the frame geometry. After
//   LOCK_FRAMES consecutive good frames it locks and emits registered pixels.
//
// Optional feature macro: CAPTURE_CRC_EN
//   Defined   : CRC-16-CCITT of each locked frame's valid pixels is reported
//               on oFRAME_CRC.
//   Undefined : no CRC logic; oFRAME_CRC is tied to 0.
//
// Ports
//   iVGA_CLK      pixel clock, all logic on posedge
//   reset         synchronous, active-high
//   iHS, iVS      syncs, active low
//   iBLANK_n      1 = active pixel
//   r_data/g_data/b_data  colour channels, COLORW bits each
//   oX, oY        active column / row of the emitted pixel
//   oRGB          {b,g,r} of the emitted pixel
//   oPIX_VALID    oX/oY/oRGB valid this cycle
//   oFRAME_START  first valid pixel of a locked frame
//   oLOCKED       geometry lock
//   oERR          1-cycle pulse: bad frame seen while locked
//   oFRAME_CNT    good locked frames (wrapping)
//   oFRAME_CRC    CRC of the last locked frame
module vga_timing_receiver #(
   parameter int unsigned COLORW      = 4,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic                  iVGA_CLK,
   input  logic                  reset,
   input  logic                  iHS,
   input  logic                  iVS,
   input  logic                  iBLANK_n,
   input  logic [COLORW-1:0]     r_data,
   input  logic [COLORW-1:0]     g_data,
   input  logic [COLORW-1:0]     b_data,
   output logic [9:0]            oX,
   output logic [8:0]            oY,
   output logic [3*COLORW-1:0]   oRGB,
   output logic                  oPIX_VALID,
   output logic                  oFRAME_START,
   output logic                  oLOCKED,
   output logic                  oERR,
   output logic [15:0]           oFRAME_CNT,
   output logic [15:0]           oFRAME_CRC
);

   localparam int unsigned RgbW = 3 * COLORW;
   localparam logic [10:0] HActW = 11'(H_ACTIVE);
   localparam logic [9:0]  VActW = 10'(V_ACTIVE);
   localparam logic [2:0]  LockW = 3'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

   // Input stage plus one extra stage of the syncs for edge detection
   logic            hs_q, hs_q2, vs_q, vs_q2, blank_q;
   logic [RgbW-1:0] rgb_q;

   state_e          state_q, state_d;
   logic [10:0]     hcnt_q, hcnt_d;
   logic [9:0]      vcnt_q, vcnt_d;
   logic            frame_bad_q, frame_bad_d;
   logic [2:0]      good_q, good_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [9:0]      x_q, x_d;
   logic [8:0]      y_q, y_d;
   logic [RgbW-1:0] rgb_out_q, rgb_out_d;
   logic            valid_q, valid_d;
   logic            fs_q, fs_d;

   logic            hs_fall, vs_fall, line_cnt, line_bad, frame_bad_eff, frame_good, pix_valid;
   logic [9:0]      vcnt_line;

   always_comb begin
      hs_fall   = hs_q2 & ~hs_q;
      vs_fall   = vs_q2 & ~vs_q;
      // Line closed before frame so a coincident HS/VS still counts the last line
      line_cnt  = hs_fall && (hcnt_q != 11'd0);
      line_bad  = line_cnt && (hcnt_q != HActW);
      vcnt_line = (line_cnt && (vcnt_q != 10'h3FF)) ? vcnt_q + 10'd1 : vcnt_q;
      frame_bad_eff = frame_bad_q | line_bad;
      frame_good    = (vcnt_line == VActW) && !frame_bad_eff;
      pix_valid     = (state_q == StLocked) && blank_q && (hcnt_q < HActW) && (vcnt_q < VActW);
   end

   always_comb begin
      hcnt_d      = hcnt_q;
      vcnt_d      = vs_fall ? 10'd0 : vcnt_line;
      frame_bad_d = vs_fall ? 1'b0 : frame_bad_eff;
      if (hs_fall) begin
         hcnt_d = 11'd0;
      end else if (blank_q && (hcnt_q != 11'h7FF)) begin
         hcnt_d = hcnt_q + 11'd1;
      end
   end

   // Geometry FSM: verdict taken only at frame end
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      if (vs_fall) begin
         unique case (state_q)
            StSearch: begin
               state_d = StMeasure;
               good_d  = 3'd0;
            end
            StMeasure: begin
               if (frame_good) begin
                  good_d = good_q + 3'd1;
                  if (good_q + 3'd1 == LockW) state_d = StLocked;
               end else begin
                  good_d = 3'd0;
               end
            end
            StLocked: begin
               if (frame_good) begin
                  cnt_d = cnt_q + 16'd1;
               end else begin
                  err_d   = 1'b1;
                  good_d  = 3'd0;
                  state_d = StMeasure;
               end
            end
            default: state_d = StSearch;
         endcase
      end
   end

   // Pixel outputs hold their last value while not valid
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      rgb_out_d = rgb_out_q;
      valid_d   = pix_valid;
      fs_d      = pix_valid && (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
      if (pix_valid) begin
         x_d       = hcnt_q[9:0];
         y_d       = vcnt_q[8:0];
         rgb_out_d = rgb_q;
      end
   end

   always_ff @(posedge iVGA_CLK) begin
      if (reset) begin
         hs_q        <= 1'b1;
         hs_q2       <= 1'b1;
         vs_q        <= 1'b1;
         vs_q2       <= 1'b1;
         blank_q     <= 1'b0;
         rgb_q       <= '0;
         state_q     <= StSearch;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         frame_bad_q <= 1'b0;
         good_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         rgb_out_q   <= '0;
         valid_q     <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         hs_q        <= iHS;
         hs_q2       <= hs_q;
         vs_q        <= iVS;
         vs_q2       <= vs_q;
         blank_q     <= iBLANK_n;
         rgb_q       <= {b_data, g_data, r_data};
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         frame_bad_q <= frame_bad_d;
         good_q      <= good_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rgb_out_q   <= rgb_out_d;
         valid_q     <= valid_d;
         fs_q        <= fs_d;
      end
   end

`ifdef CAPTURE_CRC_EN
   logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;

   // CRC-16-CCITT (0x1021), MSB first, no reflection
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RgbW-1:0] d);
      logic [15:0] r;
      r = c;
      for (int i = RgbW - 1; i >= 0; i--) begin
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   always_comb begin
      crc_d  = crc_q;
      fcrc_d = fcrc_q;
      if (vs_fall) begin
         crc_d = 16'hFFFF;
         if (state_q == StLocked) fcrc_d = crc_q;
      end else if (pix_valid) begin
         crc_d = crc_step(crc_q, rgb_q);
      end
   end

   always_ff @(posedge iVGA_CLK) begin
      if (reset) begin
         crc_q  <= 16'hFFFF;
         fcrc_q <= '0;
      end else begin
         crc_q  <= crc_d;
         fcrc_q <= fcrc_d;
      end
   end

   assign oFRAME_CRC = fcrc_q;
`else
   assign oFRAME_CRC = '0;
`endif

   assign oX           = x_q;
   assign oY           = y_q;
   assign oRGB         = rgb_out_q;
   assign oPIX_VALID   = valid_q;
   assign oFRAME_START = fs_q;
   assign oLOCKED      = (state_q == StLocked);
   assign oERR         = err_q;
   assign oFRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a reduced 8x4 geometry
// (12 clocks per line, 7 lines per frame). VS falls together with the HS
// edge that closes the last active line.
module tb_vga_timing_receiver;

   localparam int CW = 4;
   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HTOT = 12;
   localparam int VTOT = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hs = 1'b1, vs = 1'b1, blank = 1'b0;
   logic [CW-1:0] r = '0, g = '0, b = '0;
   logic [9:0]    o_x;
   logic [8:0]    o_y;
   logic [11:0]   o_rgb;
   logic          o_valid, o_fs, o_locked, o_err;
   logic [15:0]   o_cnt, o_crc;

   vga_timing_receiver #(
      .COLORW(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .iVGA_CLK(clk), .reset(reset), .iHS(hs), .iVS(vs), .iBLANK_n(blank),
      .r_data(r), .g_data(g), .b_data(b),
      .oX(o_x), .oY(o_y), .oRGB(o_rgb), .oPIX_VALID(o_valid), .oFRAME_START(o_fs),
      .oLOCKED(o_locked), .oERR(o_err), .oFRAME_CNT(o_cnt), .oFRAME_CRC(o_crc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          x;
      int          y;
      logic [11:0] rgb;
      logic        fs;
      int          cyc;
   } pix_t;

   pix_t        exp_q[$];
   int          err_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [15:0] mcrc = 16'hFFFF;
   logic [15:0] crc_a;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] v;
      logic        fb;
      v = c;
      for (int i = 11; i >= 0; i--) begin
         fb = v[15] ^ d[i];
         v  = {v[14:0], 1'b0};
         if (fb) v = v ^ 16'h1021;
      end
      return v;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a pixel
   initial begin
      pix_t        e;
      int          ec;
      logic [9:0]  lx = '0;
      logic [8:0]  ly = '0;
      logic [11:0] lrgb = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            lx = '0; ly = '0; lrgb = '0;
         end else if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pixel", {o_x, o_y}, 64'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("pix_x", o_x, e.x);
               check("pix_y", o_y, e.y);
               check("pix_rgb", o_rgb, e.rgb);
               check("pix_frame_start", o_fs, e.fs);
               check("pix_latency_cycle", cyc, e.cyc);
            end
            lx = o_x; ly = o_y; lrgb = o_rgb;
         end else begin
            check("hold_xyrgb", {o_x, o_y, o_rgb}, {lx, ly, lrgb});
            check("frame_start_idle", o_fs, 1'b0);
         end
         if (!reset && o_err) begin
            if (err_q.size() == 0) begin
               check("unexpected_err", o_err, 1'b0);
            end else begin
               ec = err_q.pop_front();
               check("err_cycle", cyc, ec);
            end
         end
      end
   end

   // Drives lines first_line..last_line of one frame. Pixels of a locked
   // frame are pushed to the scoreboard with their expected output cycle.
   task automatic send_frame(input int first_line, input int last_line, input bit locked,
                             input int long_y, input bit zeros, input int spot_x,
                             input int spot_y, input logic [11:0] spot_rgb, input bit exp_err);
      int          act;
      logic [11:0] px;
      pix_t        e;
      if (first_line == 0) mcrc = 16'hFFFF;
      for (int l = first_line; l <= last_line; l++) begin
         act = (l < VA) ? ((l == long_y) ? HA + 1 : HA) : 0;
         for (int c = 0; c < HTOT; c++) begin
            px = zeros ? 12'h000 : 12'((l * 16 + c) * 37 + 5);
            if (c == spot_x && l == spot_y) px = spot_rgb;
            @(negedge clk);
            hs        = !(c == 9 || c == 10);
            vs        = !((l == 3 && c >= 9) || (l == 4 && c < 9));
            blank     = (c < act);
            {b, g, r} = px;
            if (locked && c < act && c < HA && l < VA) begin
               e.x = c; e.y = l; e.rgb = px; e.fs = (c == 0 && l == 0); e.cyc = cyc + 2;
               exp_q.push_back(e);
               mcrc = crc_model(mcrc, px);
            end
            if (exp_err && l == 3 && c == 9) err_q.push_back(cyc + 2);
         end
      end
   endtask

   task automatic frame_status(input string name, input logic lk, input logic [15:0] cnt);
      check({name, "_locked"}, o_locked, lk);
      check({name, "_frame_cnt"}, o_cnt, cnt);
   endtask

   task automatic crc_check(input string name);
`ifdef CAPTURE_CRC_EN
      check(name, o_crc, mcrc);
`else
      check(name, o_crc, 16'h0000);
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_pixel_outputs", {o_x, o_y, o_rgb, o_valid, o_fs}, 64'h0);
      check("reset_status_outputs", {o_locked, o_err, o_cnt, o_crc}, 64'h0);
      reset = 1'b0;

      // partial frame, then two good frames -> lock at third frame end
      send_frame(2, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("partial", 0, 16'd0);
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("good1", 0, 16'd0);
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("good2", 1, 16'd0);

      // locked frame with a marked pixel 0xABC at column 5, row 2
      send_frame(0, VTOT - 1, 1, -1, 0, 5, 2, 12'hABC, 0);
      frame_status("locked3", 1, 16'd1);
      crc_check("crc_locked3");

      // over-length line 1: ninth pixel suppressed, error at frame end
      send_frame(0, VTOT - 1, 1, 1, 0, -1, -1, 12'h0, 1);
      frame_status("long_line", 0, 16'd1);
      crc_check("crc_long_line");
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("relock1", 0, 16'd1);
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("relock2", 1, 16'd1);

      // constant-zero frame, then the same with one pixel changed
      send_frame(0, VTOT - 1, 1, -1, 1, -1, -1, 12'h0, 0);
      frame_status("zero_frame", 1, 16'd2);
      crc_check("crc_zero_frame");
      crc_a = o_crc;
      send_frame(0, VTOT - 1, 1, -1, 1, 3, 1, 12'h001, 0);
      frame_status("one_pixel_frame", 1, 16'd3);
      crc_check("crc_one_pixel_frame");
`ifdef CAPTURE_CRC_EN
      check("crc_changed", (o_crc != crc_a), 1'b1);
`endif

      // frame counter wrap
      @(negedge clk);
      force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
      @(negedge clk);
      check("cnt_forced", o_cnt, 16'hFFFF);
      send_frame(0, VTOT - 1, 1, -1, 0, -1, -1, 12'h0, 0);
      frame_status("wrap", 1, 16'h0000);

      // reset for three clocks in the middle of a locked frame
      send_frame(0, 1, 1, -1, 0, -1, -1, 12'h0, 0);
      @(negedge clk);
      reset = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset_pixel_outputs", {o_x, o_y, o_rgb, o_valid, o_fs}, 64'h0);
      check("midreset_status_outputs", {o_locked, o_err, o_cnt, o_crc}, 64'h0);
      reset = 1'b0;
      send_frame(2, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("post_reset_partial", 0, 16'd0);
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("post_reset_good1", 0, 16'd0);
      send_frame(0, VTOT - 1, 0, -1, 0, -1, -1, 12'h0, 0);
      frame_status("post_reset_good2", 1, 16'd0);

      repeat (5) @(negedge clk);
      check("pixels_outstanding", exp_q.size(), 0);
      check("errs_outstanding", err_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
